// File: rtl/dsp_cfg_master.sv
// -----------------------------------------------------------------------------
// dsp_cfg_master
// Host-side initiator for the dsp_top configuration port. Burst commands come
// in over a valid/ready handshake and go out as single-word bus transactions.
// Write bursts stream words into coefficient memory. Read bursts return words
// on a one-cycle-pulse read stream.
//
// Parameters
//   READ_LAT     : bus read latency in cycles (1..4)
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   cmd_*        : burst command (rw: 1 = write, addr, len; len 0 means 1)
//   wr_*         : write-data stream (valid/ready)
//   rd_*         : read-data stream (valid pulse, data, last)
//   done         : one-cycle pulse at command completion
//   err          : sticky read-back mismatch flag
//   msg_in, rw, mem_addr, coeff_in, mem_read_out : dsp_top bus
// Optional feature
//   DSP_CFG_VERIFY_EN : when defined, every written word is read back and
//                       compared; a mismatch sets err.
// -----------------------------------------------------------------------------
module dsp_cfg_master #(
    parameter int READ_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [9:0] cmd_addr,
    input  logic [7:0] cmd_len,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_last,
    output logic       done,
    output logic       err,
    output logic       msg_in,
    output logic       rw,
    output logic [9:0] mem_addr,
    output logic [7:0] coeff_in,
    input  logic [7:0] mem_read_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
`ifdef DSP_CFG_VERIFY_EN
        S_VRD   = 3'd4,
        S_VWAIT = 3'd5,
`endif
        S_DRAIN = 3'd3
    } state_t;

    state_t                state_q;
    logic [9:0]            addr_q;
    logic [7:0]            cnt_q;        // words still to transfer
    logic                  dir_q;        // 1 = current burst is a write
    logic                  cmd_ready_q;
    logic                  wr_ready_q;
    logic                  msg_in_q;
    logic                  rw_q;
    logic [9:0]            mem_addr_q;
    logic [7:0]            coeff_in_q;
    logic                  issue_q;      // a stream read is on the bus this cycle
    logic                  issue_last_q; // ... and it is the final one
    logic [READ_LAT-1:0]   tag_v_q;      // in-flight read tags
    logic [READ_LAT-1:0]   tag_l_q;      // last-word marker per tag
    logic                  rd_valid_q;
    logic [7:0]            rd_data_q;
    logic                  rd_last_q;
    logic                  done_q;

    logic [9:0]            addr_d;
    logic [7:0]            cnt_d;
    logic                  wr_fire_s;
    logic                  last_s;
    logic                  pend_s;
    logic                  drain_done_s;

`ifdef DSP_CFG_VERIFY_EN
    localparam logic [2:0] LAT_W = 3'(READ_LAT);
    logic                  err_q;
    logic [2:0]            wcnt_q;
    logic                  cmp_pend_q;   // compare happens at the coming edge
    logic [7:0]            cmp_data_q;
    assign pend_s = cmp_pend_q;
    assign err    = err_q;
`else
    assign pend_s = 1'b0;
    assign err    = 1'b0;
`endif

    // Next-address/count arithmetic and completion condition for DRAIN.
    always_comb begin
        addr_d    = addr_q + 10'd1;   // wraps modulo 1024
        cnt_d     = cnt_q - 8'd1;
        wr_fire_s = wr_valid && wr_ready_q;
        last_s    = (cnt_q == 8'd1);
        // Writes finish once no verify compare is pending; reads finish on the
        // edge that ends the final rd_valid pulse.
        if (dir_q) begin
            drain_done_s = !pend_s;
        end else begin
            drain_done_s = rd_valid_q && rd_last_q;
        end
    end

    // Control FSM, bus driver, read-tag pipeline and read-data stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= 10'd0;
            cnt_q        <= 8'd0;
            dir_q        <= 1'b0;
            cmd_ready_q  <= 1'b0;
            wr_ready_q   <= 1'b0;
            msg_in_q     <= 1'b0;
            rw_q         <= 1'b0;
            mem_addr_q   <= 10'd0;
            coeff_in_q   <= 8'd0;
            issue_q      <= 1'b0;
            issue_last_q <= 1'b0;
            tag_v_q      <= {READ_LAT{1'b0}};
            tag_l_q      <= {READ_LAT{1'b0}};
            rd_valid_q   <= 1'b0;
            rd_data_q    <= 8'd0;
            rd_last_q    <= 1'b0;
            done_q       <= 1'b0;
`ifdef DSP_CFG_VERIFY_EN
            err_q        <= 1'b0;
            wcnt_q       <= 3'd0;
            cmp_pend_q   <= 1'b0;
            cmp_data_q   <= 8'd0;
`endif
        end else begin
            // Tag pipeline: tag k is valid READ_LAT-k cycles before the sample
            // edge, so the oldest tag marks the edge where mem_read_out is valid.
            tag_v_q[0] <= issue_q;
            tag_l_q[0] <= issue_last_q;
            for (int k = READ_LAT - 1; k > 0; k--) begin
                tag_v_q[k] <= tag_v_q[k-1];
                tag_l_q[k] <= tag_l_q[k-1];
            end
            rd_valid_q <= tag_v_q[READ_LAT-1];
            rd_last_q  <= tag_v_q[READ_LAT-1] && tag_l_q[READ_LAT-1];
            if (tag_v_q[READ_LAT-1]) begin
                rd_data_q <= mem_read_out;
            end else begin
                rd_data_q <= rd_data_q;
            end

            done_q       <= 1'b0;
            issue_q      <= 1'b0;
            issue_last_q <= 1'b0;

`ifdef DSP_CFG_VERIFY_EN
            if (cmp_pend_q) begin
                cmp_pend_q <= 1'b0;
                if (mem_read_out != cmp_data_q) begin
                    err_q <= 1'b1;
                end else begin
                    err_q <= err_q;
                end
            end else begin
                cmp_pend_q <= 1'b0;
            end
`endif

            case (state_q)
                S_IDLE: begin
                    msg_in_q <= 1'b0;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        cnt_q       <= (cmd_len == 8'd0) ? 8'd1 : cmd_len;
                        dir_q       <= cmd_rw;
                        wr_ready_q  <= cmd_rw;
                        state_q     <= cmd_rw ? S_WRITE : S_READ;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (wr_fire_s) begin
                        msg_in_q   <= 1'b1;
                        rw_q       <= 1'b1;
                        mem_addr_q <= addr_q;
                        coeff_in_q <= wr_data;
                        addr_q     <= addr_d;
                        cnt_q      <= cnt_d;
`ifdef DSP_CFG_VERIFY_EN
                        wr_ready_q <= 1'b0;
                        cmp_data_q <= wr_data;
                        state_q    <= S_VRD;
`else
                        if (last_s) begin
                            wr_ready_q <= 1'b0;
                            state_q    <= S_DRAIN;
                        end else begin
                            wr_ready_q <= 1'b1;
                        end
`endif
                    end else begin
                        msg_in_q <= 1'b0;
                    end
                end
                S_READ: begin
                    msg_in_q     <= 1'b1;
                    rw_q         <= 1'b0;
                    mem_addr_q   <= addr_q;
                    addr_q       <= addr_d;
                    cnt_q        <= cnt_d;
                    issue_q      <= 1'b1;
                    issue_last_q <= last_s;
                    if (last_s) begin
                        state_q <= S_DRAIN;
                    end else begin
                        state_q <= S_READ;
                    end
                end
`ifdef DSP_CFG_VERIFY_EN
                S_VRD: begin
                    // Read back the address just written; mem_addr already holds it.
                    msg_in_q <= 1'b1;
                    rw_q     <= 1'b0;
                    wcnt_q   <= 3'd1;
                    state_q  <= S_VWAIT;
                end
                S_VWAIT: begin
                    msg_in_q <= 1'b0;
                    // Arm the compare and reopen wr_ready together, so the next
                    // word is taken on the same edge the compare is made.
                    if (wcnt_q == LAT_W) begin
                        cmp_pend_q <= 1'b1;
                        if (cnt_q == 8'd0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            wr_ready_q <= 1'b1;
                            state_q    <= S_WRITE;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + 3'd1;
                    end
                end
`endif
                S_DRAIN: begin
                    msg_in_q <= 1'b0;
                    if (drain_done_s) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                default: begin
                    msg_in_q    <= 1'b0;
                    wr_ready_q  <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign msg_in    = msg_in_q;
    assign rw        = rw_q;
    assign mem_addr  = mem_addr_q;
    assign coeff_in  = coeff_in_q;

endmodule

// File: tb/tb_dsp_cfg_master.sv
// Self-checking bench for dsp_cfg_master: bus memory model, output monitor,
// a table of read bursts plus hand-written write/stall/reset sequences.
module tb_dsp_cfg_master;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [9:0] cmd_addr = 10'd0;
    logic [7:0] cmd_len = 8'd0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'd0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       done;
    logic       err;
    logic       msg_in;
    logic       rw;
    logic [9:0] mem_addr;
    logic [7:0] coeff_in;
    logic [7:0] mem_read_out;

    dsp_cfg_master #(.READ_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .msg_in(msg_in), .rw(rw), .mem_addr(mem_addr), .coeff_in(coeff_in),
        .mem_read_out(mem_read_out)
    );

    always #5 clk = ~clk;

    // Bus memory model: unwritten word i holds i[7:0]^0x5A; reads have LAT latency.
    logic       mem_init = 1'b1;
    logic [7:0] bmem [0:1023];
    logic [9:0] rp [LAT];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) bmem[i] <= 8'(i) ^ 8'h5A;
        end else if (msg_in && rw) begin
            bmem[mem_addr] <= coeff_in;
        end
        rp[0] <= mem_addr;
        for (int k = 1; k < LAT; k++) rp[k] <= rp[k-1];
    end
    assign mem_read_out = bmem[rp[LAT-1]];

    // Monitor
    int cyc = 0;
    int raddr_q[$], raddr_cyc[$], rdat_q[$], rlast_q[$], rcyc_q[$];
    int done_cnt = 0, done_cyc = 0, rd_in_idle = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (msg_in && !rw) begin raddr_q.push_back(int'(mem_addr)); raddr_cyc.push_back(cyc); end
        if (rd_valid) begin
            rdat_q.push_back(int'(rd_data)); rlast_q.push_back(int'(rd_last)); rcyc_q.push_back(cyc);
            if (cmd_ready) rd_in_idle = rd_in_idle + 1;
        end
        if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    end

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic send_cmd(input logic r, input logic [9:0] a, input logic [7:0] l);
        int g = 0;
        cmd_valid = 1'b1; cmd_rw = r; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        chk("cmd_accept_timeout", int'(cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic write_words(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            wr_valid = 1'b1; wr_data = base + 8'(i);
            while (!wr_ready && g < 20) begin @(negedge clk); g++; end
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int start = done_cnt;
        int g = 0;
        while (done_cnt == start && g < budget) begin @(negedge clk); g++; end
        @(negedge clk);
        chk(nm, done_cnt - start, 1);
    endtask

    function automatic int all_outs();
        return int'({cmd_ready, wr_ready, msg_in, rw, mem_addr, coeff_in,
                     rd_valid, rd_data, rd_last, done, err});
    endfunction

    typedef struct {
        logic [9:0] addr;
        logic [7:0] len;
        int         n_exp;
        logic [7:0] d_first;
        logic [7:0] d_last;
    } rvec_t;
    rvec_t tab [5];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dc;
        tab[0] = '{10'd133,  8'd1, 1, 8'hFD, 8'hFD};
        tab[1] = '{10'd128,  8'd3, 3, 8'hF8, 8'hFA};
        tab[2] = '{10'd1022, 8'd3, 3, 8'hA4, 8'h5A};
        tab[3] = '{10'd200,  8'd0, 1, 8'h92, 8'h92};
        tab[4] = '{10'd198,  8'd2, 2, 8'h3E, 8'h9D};

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", int'(cmd_ready), 1);

        // Back-to-back write burst at 128: 00, FF, FE
        send_cmd(1'b1, 10'd128, 8'd3);
        wr_valid = 1'b1; wr_data = 8'h00;
        @(negedge clk);
        chk("wb0_bus", int'({msg_in, rw, mem_addr, coeff_in}), int'({1'b1, 1'b1, 10'd128, 8'h00}));
        wr_data = 8'hFF;
        @(negedge clk);
        chk("wb1_bus", int'({msg_in, rw, mem_addr, coeff_in}), int'({1'b1, 1'b1, 10'd129, 8'hFF}));
        wr_data = 8'hFE;
        @(negedge clk);
        chk("wb2_bus", int'({msg_in, rw, mem_addr, coeff_in}), int'({1'b1, 1'b1, 10'd130, 8'hFE}));
        wr_valid = 1'b0;
        dc = done_cnt;
        @(negedge clk);
        chk("wb_done_pulse", int'({done, msg_in, cmd_ready}), int'({1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        chk("wb_done_once", int'({done, cmd_ready}), int'({1'b0, 1'b1}));
        chk("wb_done_count", done_cnt - dc, 1);

        // Load 71 I coefficients at 128 with data F8+k
        send_cmd(1'b1, 10'd128, 8'd71);
        write_words(71, 8'hF8);
        wait_done("load_done", 20);

        // Read bursts from the table
        for (int v = 0; v < 5; v++) begin
            int ls;
            raddr_q.delete(); raddr_cyc.delete(); rdat_q.delete(); rlast_q.delete(); rcyc_q.delete();
            send_cmd(1'b0, tab[v].addr, tab[v].len);
            wait_done($sformatf("rd%0d_done", v), 40);
            chk($sformatf("rd%0d_n_addr", v), raddr_q.size(), tab[v].n_exp);
            chk($sformatf("rd%0d_n_data", v), rdat_q.size(), tab[v].n_exp);
            for (int k = 0; k < tab[v].n_exp && k < raddr_q.size(); k++)
                chk($sformatf("rd%0d_addr%0d", v, k), raddr_q[k], (int'(tab[v].addr) + k) % 1024);
            if (rdat_q.size() > 0 && raddr_q.size() > 0) begin
                chk($sformatf("rd%0d_first", v), rdat_q[0], int'(tab[v].d_first));
                chk($sformatf("rd%0d_last_data", v), rdat_q[rdat_q.size()-1], int'(tab[v].d_last));
                chk($sformatf("rd%0d_last_flag", v), rlast_q[rlast_q.size()-1], 1);
                chk($sformatf("rd%0d_latency", v), rcyc_q[0] - raddr_cyc[0], LAT + 1);
                chk($sformatf("rd%0d_done_cyc", v), done_cyc, rcyc_q[rcyc_q.size()-1] + 1);
            end else begin
                chk($sformatf("rd%0d_no_data", v), 0, 1);
            end
            ls = 0;
            foreach (rlast_q[k]) ls += rlast_q[k];
            chk($sformatf("rd%0d_last_count", v), ls, 1);
        end

        // Write stall: wr_valid 1,0,1 at 300
        send_cmd(1'b1, 10'd300, 8'd2);
        wr_valid = 1'b1; wr_data = 8'h11;
        @(negedge clk);
        chk("ws0_bus", int'({msg_in, rw, mem_addr, coeff_in}), int'({1'b1, 1'b1, 10'd300, 8'h11}));
        wr_valid = 1'b0;
        @(negedge clk);
        chk("ws_bubble", int'({msg_in, mem_addr}), int'({1'b0, 10'd300}));
        wr_valid = 1'b1; wr_data = 8'h22;
        @(negedge clk);
        chk("ws1_bus", int'({msg_in, rw, mem_addr, coeff_in}), int'({1'b1, 1'b1, 10'd301, 8'h22}));
        wr_valid = 1'b0;
        @(negedge clk);
        chk("ws_done", int'(done), 1);

        // Reset two words into a len-10 write
        @(negedge clk);
        send_cmd(1'b1, 10'd400, 8'd10);
        write_words(2, 8'h40);
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_ready", int'({cmd_ready, wr_ready, msg_in}), int'({1'b1, 1'b0, 1'b0}));
        repeat (5) @(negedge clk);
        chk("midrst_no_done", done_cnt - dc, 0);

        chk("rd_valid_in_idle", rd_in_idle, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
